// File: rtl/fpusb_pkg.sv
// fpusb_pkg: shared constants for the FPU -> USB result path.
//   FPU_WORD_W    result word width (matches the PipeReg data width)
//   FPU_PIPE_LAT  PipeReg latency in clk_pll cycles
//   RESBUF_DEPTH  result FIFO entries (power of two)
//   RESBUF_OCC_W  width of an occupancy / credit count (0..RESBUF_DEPTH)
package fpusb_pkg;
    localparam int FPU_WORD_W   = 27;
    localparam int FPU_PIPE_LAT = 2;
    localparam int RESBUF_DEPTH = 8;
    localparam int RESBUF_OCC_W = $clog2(RESBUF_DEPTH + 1);
endpackage

// File: rtl/fpu_resbuf_fifo.sv
// fpu_resbuf_fifo: synchronous FIFO holding FPU results for the USB side.
// Ports:
//   clk_pll    clock, all updates on the rising edge
//   rst        synchronous active-high reset (pointers and count only)
//   flush      synchronous clear, same effect as rst
//   push       write push_data at the tail (ignored when full)
//   push_data  word to write
//   pop_ready  consumer accepts the head; a pop happens when rd_valid is high too
//   rd_valid   head holds a word
//   rd_data    head word, registered storage, no write-through bypass
//   occupancy  number of stored words
// Storage is not reset, so rd_data is meaningless while rd_valid is low.
module fpu_resbuf_fifo
    import fpusb_pkg::*;
#(
    parameter int W     = FPU_WORD_W,
    parameter int DEPTH = RESBUF_DEPTH
) (
    input  logic                         clk_pll,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  logic [W-1:0]                 push_data,
    input  logic                         pop_ready,
    output logic                         rd_valid,
    output logic [W-1:0]                 rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;
    logic             empty;
    logic             full;
    logic             do_push;
    logic             do_pop;

    // Full/empty come from the count so the pointers can wrap freely.
    assign empty   = (occ == '0);
    assign full    = (occ == OCC_W'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop_ready && !empty;

    assign rd_valid  = !empty;
    assign rd_data   = mem[rd_ptr];
    assign occupancy = occ;

    always_ff @(posedge clk_pll) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk_pll) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end
endmodule

// File: rtl/fpu_result_buffer.sv
// fpu_result_buffer: captures results leaving the fixed-latency FPU pipe and
// buffers them for the USB transmit side, issuing credits upstream so the pipe
// never delivers a result without a free slot.
// Ports:
//   clk_pll      sole clock
//   rst          synchronous active-high reset
//   flush        (only with FPU_RESBUF_FLUSH_EN) synchronous clear of tags,
//                in-flight count and FIFO; an issue in the same cycle is dropped
//   issue_valid  operands presented to the pipe this cycle
//   issue_ready  a credit is available
//   pipe_out     PipeReg output word
//   res_valid    FIFO head holds a result
//   res_data     FIFO head word
//   res_ready    consumer takes the head
//   occupancy    number of stored results
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high; valid never depends combinationally on ready, and issue_ready depends
// on registered state only (a pop in the same cycle does not return a credit).
// Optional feature macro: FPU_RESBUF_FLUSH_EN.
module fpu_result_buffer
    import fpusb_pkg::*;
#(
    parameter int num_of_bits  = FPU_WORD_W,
    parameter int num_of_pipes = FPU_PIPE_LAT,
    parameter int depth        = RESBUF_DEPTH
) (
    input  logic                         clk_pll,
    input  logic                         rst,
`ifdef FPU_RESBUF_FLUSH_EN
    input  logic                         flush,
`endif
    input  logic                         issue_valid,
    output logic                         issue_ready,
    input  logic [num_of_bits-1:0]       pipe_out,
    output logic                         res_valid,
    output logic [num_of_bits-1:0]       res_data,
    input  logic                         res_ready,
    output logic [$clog2(depth+1)-1:0]   occupancy
);
    localparam int OCC_W = $clog2(depth + 1);
    localparam int SUM_W = OCC_W + 1;

    logic                    flush_i;
    logic [num_of_pipes-1:0] tag;
    logic [OCC_W-1:0]        inflight;
    logic [SUM_W-1:0]        credit_used;
    logic                    issue_fire;
    logic                    result_wr;

`ifdef FPU_RESBUF_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    // Every issued word is either in the pipe (inflight) or in the FIFO, so
    // this sum bounds what can still arrive; a write can never meet a full FIFO.
    assign credit_used = {1'b0, inflight} + {1'b0, occupancy};
    assign issue_ready = (credit_used < SUM_W'(depth));
    assign issue_fire  = issue_valid && issue_ready && !flush_i;

    // The oldest tag lines up with pipe_out: its word is valid this cycle.
    assign result_wr = tag[num_of_pipes-1];

    always_ff @(posedge clk_pll) begin
        if (rst || flush_i) begin
            tag      <= '0;
            inflight <= '0;
        end else begin
            tag[0] <= issue_fire;
            for (int i = 1; i < num_of_pipes; i++) begin
                tag[i] <= tag[i-1];
            end
            case ({issue_fire, result_wr})
                2'b10:   inflight <= inflight + OCC_W'(1);
                2'b01:   inflight <= inflight - OCC_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    fpu_resbuf_fifo #(
        .W     (num_of_bits),
        .DEPTH (depth)
    ) u_fifo (
        .clk_pll   (clk_pll),
        .rst       (rst),
        .flush     (flush_i),
        .push      (result_wr),
        .push_data (pipe_out),
        .pop_ready (res_ready),
        .rd_valid  (res_valid),
        .rd_data   (res_data),
        .occupancy (occupancy)
    );
endmodule

// File: tb/tb_fpu_result_buffer.sv
// tb_fpu_result_buffer: self-checking bench for fpu_result_buffer.
// The bench plays the role of the FPU pipe: a word issued in cycle c is driven
// on pipe_out in cycle c+P. A queue model of "issued but not yet consumed"
// words predicts every output each cycle.
module tb_fpu_result_buffer;
    localparam int W = 27;
    localparam int P = 2;
    localparam int D = 8;

    logic         clk_pll = 1'b0;
    logic         rst;
    logic         flush;
    logic         issue_valid;
    logic         issue_ready;
    logic [W-1:0] pipe_out;
    logic         res_valid;
    logic [W-1:0] res_data;
    logic         res_ready;
    logic [3:0]   occupancy;
    logic [W-1:0] issue_word;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    bit armed = 0;

    // Model: words issued and not yet popped, with the first cycle each one
    // may appear at the output (issue cycle + P + 1).
    logic [W-1:0] exp_q[$];
    int           vis_q[$];
    // Fire history, used to emulate the pipe's output word.
    bit           hist_v[8];
    logic [W-1:0] hist_d[8];

    fpu_result_buffer dut (
        .clk_pll     (clk_pll),
        .rst         (rst),
`ifdef FPU_RESBUF_FLUSH_EN
        .flush       (flush),
`endif
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .pipe_out    (pipe_out),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .res_ready   (res_ready),
        .occupancy   (occupancy)
    );

    // clock
    always #5 clk_pll = ~clk_pll;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // compare process: check outputs mid-cycle, then advance the model
    always @(negedge clk_pll) begin
        int  occ_e;
        bit  rv_e;
        bit  ir_e;
        bit  fire;
        occ_e = 0;
        foreach (vis_q[i]) if (vis_q[i] <= cyc) occ_e++;
        rv_e = (exp_q.size() > 0) && (vis_q[0] <= cyc);
        ir_e = (exp_q.size() < D);
        if (armed) begin
            check("issue_ready", 32'(issue_ready), 32'(ir_e));
            check("res_valid", 32'(res_valid), 32'(rv_e));
            check("occupancy", 32'(occupancy), 32'(occ_e));
            if (rv_e) check("res_data", 32'(res_data), 32'(exp_q[0]));
        end
        if (rst || (armed && flush)) begin
            exp_q.delete();
            vis_q.delete();
            foreach (hist_v[i]) hist_v[i] = 0;
            armed = 1;
        end else if (armed) begin
            if (rv_e && res_ready) begin
                void'(exp_q.pop_front());
                void'(vis_q.pop_front());
            end
            fire = issue_valid && ir_e;
            if (fire) begin
                exp_q.push_back(issue_word);
                vis_q.push_back(cyc + P + 1);
            end
            hist_v[cyc % 8] = fire;
            hist_d[cyc % 8] = issue_word;
        end
        cyc++;
    end

    // driver: set the inputs of one cycle just after the rising edge
    task automatic tick(input bit iv, input logic [W-1:0] word, input bit rr, input bit r, input bit fl);
        int s;
        @(posedge clk_pll);
        #1;
        issue_valid = iv;
        issue_word  = word;
        res_ready   = rr;
        rst         = r;
        flush       = fl;
        s = (cyc + 8 - P) % 8;
        pipe_out = hist_v[s] ? hist_d[s] : W'($urandom);
    endtask

    task automatic idle(input int n, input bit rr);
        for (int i = 0; i < n; i++) tick(0, '0, rr, 0, 0);
    endtask

    initial begin
        rst = 1; flush = 0; issue_valid = 0; res_ready = 0;
        issue_word = '0; pipe_out = '0;

        // reset
        tick(0, '0, 0, 1, 0);
        tick(0, '0, 0, 1, 0);
        tick(0, '0, 0, 0, 0);
        check("reset issue_ready", 32'(issue_ready), 32'd1);
        check("reset res_valid", 32'(res_valid), 32'd0);
        check("reset occupancy", 32'(occupancy), 32'd0);

        // single issue: visible exactly 3 cycles later, for one cycle
        tick(1, 27'h1ABCDEF, 1, 0, 0);
        idle(2, 1);
        check("single early", 32'(res_valid), 32'd0);
        idle(1, 1);
        check("single valid", 32'(res_valid), 32'd1);
        check("single data", 32'(res_data), 32'h1ABCDEF);
        idle(1, 1);
        check("single gone", 32'(res_valid), 32'd0);

        // eight back-to-back issues with the consumer stalled
        for (int i = 0; i < 8; i++) tick(1, W'(32'h100 + i), 0, 0, 0);
        tick(1, W'($urandom), 0, 0, 0);
        check("full issue_ready", 32'(issue_ready), 32'd0);
        for (int i = 0; i < 4; i++) tick(1, W'($urandom), 0, 0, 0);
        check("full occupancy", 32'(occupancy), 32'd8);
        check("full head", 32'(res_data), 32'h100);

        // drain while issuing continuously (pointers wrap)
        for (int i = 0; i < 20; i++) tick(1, W'($urandom), 1, 0, 0);
        idle(12, 1);
        check("drained", 32'(occupancy), 32'd0);

        // random traffic
        for (int i = 0; i < 10000; i++)
            tick(1'($urandom_range(0, 1)), W'($urandom), ($urandom_range(0, 3) != 0), 0, 0);
        idle(12, 1);

        // reset with 5 stored and 2 in flight
        for (int i = 0; i < 5; i++) tick(1, W'(32'h200 + i), 0, 0, 0);
        idle(3, 0);
        check("pre-reset occupancy", 32'(occupancy), 32'd5);
        tick(1, W'(32'h300), 0, 0, 0);
        tick(1, W'(32'h301), 0, 0, 0);
        tick(0, '0, 0, 1, 0);
        tick(0, '0, 1, 0, 0);
        check("post-reset res_valid", 32'(res_valid), 32'd0);
        check("post-reset occupancy", 32'(occupancy), 32'd0);
        check("post-reset issue_ready", 32'(issue_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            tick(0, '0, 1, 0, 0);
            check("no stale result", 32'(res_valid), 32'd0);
        end

`ifdef FPU_RESBUF_FLUSH_EN
        // flush with 3 stored and an issue in the same cycle
        for (int i = 0; i < 3; i++) tick(1, W'(32'h400 + i), 0, 0, 0);
        idle(3, 0);
        check("pre-flush occupancy", 32'(occupancy), 32'd3);
        tick(1, W'(32'h4FF), 0, 0, 1);
        tick(0, '0, 1, 0, 0);
        check("post-flush occupancy", 32'(occupancy), 32'd0);
        check("post-flush issue_ready", 32'(issue_ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("post-flush res_valid", 32'(res_valid), 32'd0);
            tick(0, '0, 1, 0, 0);
        end
`endif

        idle(2, 1);
        @(negedge clk_pll);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fpu_result_buffer.md
# fpu_result_buffer

Collects results leaving the fixed-latency FPU pipeline (the PipeReg delay chain clocked by `clk_pll`) and holds them for the USB transmit side. A valid-tag shift register runs beside the datapath, so each result is captured exactly when it emerges from the pipe. The block also issues credits upstream so that the pipe never produces a result with no free buffer slot.

## Interface
- `num_of_bits`, 27: result word width; equals the PipeReg data width.
- `num_of_pipes`, 2: PipeReg latency in cycles, ≥1.
- `depth`, 8: result FIFO entries, power of two, ≥2.

- `clk_pll`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `issue_valid`  in  1  operands are presented to the pipe this cycle.
- `issue_ready`  out  1  a credit is available; an issue fires when `issue_valid && issue_ready`.
- `pipe_out`  in  num_of_bits  PipeReg output word.
- `res_valid`  out  1  FIFO head holds a result.
- `res_data`  out  num_of_bits  FIFO head word.
- `res_ready`  in  1  consumer takes the head when `res_valid` is also high.
- `occupancy`  out  clog2(depth+1)  number of FIFO entries.

## Operation
- Tag shift register `tag[num_of_pipes-1:0]`:
  - `tag[0] <= issue fire`; `tag[i] <= tag[i-1]`.
  - `tag[num_of_pipes-1]` high means `pipe_out` holds a valid result this cycle. That result is written to the FIFO tail.
- `inflight` = population count of the tag register, kept as a counter: +1 on issue, −1 on write, net 0 when both occur.
- `issue_ready = (inflight + occupancy) < depth`, computed from registered state only.
  - A pop in the same cycle does not raise `issue_ready` (conservative).
  - A write can therefore never meet a full FIFO.
- FIFO behaviour:
  - Pop when `res_valid && res_ready`.
  - Simultaneous write and pop: pointers advance together and `occupancy` is unchanged.
  - Write while empty: the word is visible on `res_data` the next cycle. There is no bypass.
- Pointers are `clog2(depth)` bits wide and wrap naturally. Full and empty are derived from `occupancy`.
- `res_data` is stable while `res_valid && !res_ready`.
- `issue_valid` while `!issue_ready` is ignored: no tag enters and no state changes.

## Timing
- Reset values: `issue_ready`=1, `res_valid`=0, `occupancy`=0. Tags, pointers and counters are cleared. FIFO storage is not reset, so `res_data` is don't-care while `res_valid`=0.
- Issue at cycle N → the result is written at edge N+`num_of_pipes` → `res_valid` is high in cycle N+`num_of_pipes`+1. With `res_ready` held high, the pop occurs in that same cycle.
- Back-to-back issues give one result per cycle at the output, sustained when `res_ready`=1 and `depth` ≥ `num_of_pipes`+1.
- Reset asserted mid-operation: all tags are discarded on that edge and in-flight results are lost. `pipe_out` contents after reset are ignored until new tags arrive.

## Configuration
- `FPU_RESBUF_FLUSH_EN` defined: adds input `flush` (1 bit, synchronous, active-high).
  - On a flush edge, all tags, `inflight` and the FIFO are cleared, so `res_valid`=0 and `issue_ready`=1 next cycle.
  - An issue in the same cycle as `flush` is dropped.
  - `rst` takes priority over `flush`.
- Undefined: the port is absent and the flush logic is not built.

## Structure
- Shared package `fpusb_pkg`:
  - `FPU_WORD_W`=27
  - `FPU_PIPE_LAT`=2
  - `RESBUF_DEPTH`=8
  - an occupancy-width localparam derived via `$clog2`
- One sub-module, `fpu_resbuf_fifo`: a synchronous FIFO with push/pop, occupancy output and `flush`/`rst` clears.
- The tag shift register and credit logic stay in the top module.

## Test plan
- Reset then a single issue of `0x1ABCDEF` with `res_ready`=1 → `res_valid` is high exactly 3 cycles after the issue with `res_data`=`0x1ABCDEF`, then low again.
- 8 back-to-back issues with `res_ready`=0 → `issue_ready` drops after the 8th fire, `occupancy` reaches 8, and further `issue_valid` creates no tags.
- Fill to 8, then `res_ready`=1 for 20 cycles while issuing continuously → output order matches issue order, no word is lost or duplicated, and pointers wrap twice.
- Random `issue_valid`/`res_ready` for 10k cycles against a scoreboard → in-order delivery and `inflight+occupancy` ≤ 8 at all times.
- Assert `rst` with 2 tags in flight and 5 entries stored → next cycle `res_valid`=0, `occupancy`=0, `issue_ready`=1, and no stale result appears afterwards.
- With `FPU_RESBUF_FLUSH_EN`: pulse `flush` in the same cycle as an issue, with 3 entries stored → everything is cleared and no output appears within the following 5 cycles.
